// File: rtl/gonso_pkg.sv
// gonso_pkg: shared definitions for the multi-channel gonso engine.
// Holds the register map offsets, channel stride, engine state encoding
// and a byte-lane merge helper used by every writable register.
package gonso_pkg;

    // Per-channel register offsets inside one channel window.
    localparam logic [3:0]  REG_IN     = 4'h0;
    localparam logic [3:0]  REG_OUT    = 4'h4;
    localparam logic [3:0]  REG_COLOR  = 4'h8;
    localparam logic [3:0]  REG_STATUS = 4'hC;

    // Global register offsets.
    localparam logic [11:0] REG_CTRL   = 12'h800;
    localparam logic [11:0] REG_MASK   = 12'h804;
    localparam logic [11:0] REG_PEND   = 12'h808;
    localparam logic [11:0] REG_ID     = 12'h80C;

    // Channel windows are CH_STRIDE bytes apart.
    localparam int CH_BITS   = 4;
    localparam int CH_STRIDE = 1 << CH_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_WB   = 2'd3
    } eng_state_e;

    // Replace only the byte lanes enabled in sel.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/gonso_rr_arbiter.sv
// gonso_rr_arbiter: combinational round-robin pick.
// Picks the first requesting channel strictly after last_i, wrapping.
//   req_i  : NCH request bits
//   last_i : index of the last channel served
//   gnt_o  : one-hot grant, idx_o : granted index, vld_o : any request
module gonso_rr_arbiter #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  last_i,
    output logic [NCH-1:0] gnt_o,
    output logic [IW-1:0]  idx_o,
    output logic           vld_o
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest
    // requester after last_i is the one left standing.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        cand  = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % NCH);
            if (req_i[cand]) begin
                vld_o = 1'b1;
                idx_o = cand;
            end
        end
        if (vld_o)
            gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/gonso_mch_engine.sv
// gonso_mch_engine: NCH-channel Wishbone register block sharing one
// multi-cycle "+INCR" engine, served round-robin.
//   clk, rst_n        : clock, async active-low reset
//   wbs_*             : Wishbone slave (single-cycle registered ack)
//   irq               : registered |(irq_pend & irq_mask)
//   busy_o            : engine not idle
//   ch_done_o         : one-cycle pulse on result write-back, per channel
module gonso_mch_engine
    import gonso_pkg::*;
#(
    parameter int          NCH   = 4,
    parameter int          DSIZE = 32,
    parameter int          LAT   = 4,
    parameter int          INCR  = 1,
    parameter logic [31:0] BASE  = 32'h3003_0000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           wbs_cyc_i,
    input  logic           wbs_stb_i,
    input  logic           wbs_we_i,
    input  logic [3:0]     wbs_sel_i,
    input  logic [31:0]    wbs_adr_i,
    input  logic [31:0]    wbs_dat_i,
    output logic [31:0]    wbs_dat_o,
    output logic           wbs_ack_o,
    output logic           irq,
    output logic           busy_o,
    output logic [NCH-1:0] ch_done_o
);

    localparam int          IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int          CHW      = 11 - CH_BITS;
    localparam logic [CHW-1:0] NCH_W = CHW'(NCH);
    localparam logic [7:0]  CNT_INIT = 8'(LAT - 1);
    localparam logic [31:0] ID_VAL   = {8'h00, 8'(NCH), 8'(LAT), 8'(DSIZE)};

    logic                        ack_q;
    logic [31:0]                 dat_q, rdata;
    logic                        en_q, irq_q;
    logic [NCH-1:0]              mask_q, ipend_q, ipend_d;
    logic [NCH-1:0]              pend_q, pend_d, done_q, done_d;
    logic [NCH-1:0][DSIZE-1:0]   in_q, out_q;
    logic [NCH-1:0][7:0]         color_q;
    eng_state_e                  state_q, state_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [IW-1:0]               sel_q, last_q, arb_idx;
    logic [NCH-1:0]              sel_oh_q, arb_gnt;
    logic                        arb_vld;
    logic [DSIZE-1:0]            opnd_q, result;
    logic                        start, load, wb;

    // ---------------- Wishbone decode ----------------
    logic            acc, hit, wr, rd, is_ch, wr_in;
    logic [11:0]     wb_off;
    logic [CHW-1:0]  wb_ch;
    logic [IW-1:0]   chi;

    // Any cyc&stb is acked (unmapped included); only base hits touch state.
    assign acc    = wbs_cyc_i && wbs_stb_i && !ack_q;
    assign hit    = acc && (wbs_adr_i[31:12] == BASE[31:12]);
    assign wr     = hit && wbs_we_i;
    assign rd     = hit && !wbs_we_i;
    assign wb_off = wbs_adr_i[11:0];
    assign wb_ch  = wbs_adr_i[10:CH_BITS];
    assign chi    = wb_ch[IW-1:0];
    assign is_ch  = !wbs_adr_i[11] && (wb_ch < NCH_W);
    assign wr_in  = wr && is_ch && (wbs_adr_i[3:0] == REG_IN) && (|wbs_sel_i);

    always_comb begin
        rdata = '0;
        if (is_ch) begin
            case (wbs_adr_i[3:0])
                REG_IN:     rdata = 32'(in_q[chi]);
                REG_OUT:    rdata = 32'(out_q[chi]);
                REG_COLOR:  rdata = {24'b0, color_q[chi]};
                REG_STATUS: rdata = {29'b0, done_q[chi], busy_o && (sel_q == chi), pend_q[chi]};
                default:    rdata = '0;
            endcase
        end else begin
            case (wb_off)
                REG_CTRL: rdata = {31'b0, en_q};
                REG_MASK: rdata = 32'(mask_q);
                REG_PEND: rdata = 32'(ipend_q);
                REG_ID:   rdata = ID_VAL;
                default:  rdata = '0;
            endcase
        end
    end

    // ---------------- Arbiter ----------------
    gonso_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
        .req_i  (pend_q),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .vld_o  (arb_vld)
    );

    // ---------------- Engine FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        load    = 1'b0;
        wb      = 1'b0;
        case (state_q)
            ST_IDLE: if (en_q && arb_vld) begin
                state_d = ST_LOAD;
                start   = 1'b1;
            end
            ST_LOAD: begin
                load    = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = (CNT_INIT == 8'd0) ? ST_WB : ST_CALC;
            end
            ST_CALC: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1)
                    state_d = ST_WB;
            end
            ST_WB: begin
                wb      = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign result = opnd_q + DSIZE'(INCR);

    // Status bit updates. Order matters: a software IN write overrides the
    // engine's pend clear, and a write-back set overrides a W1C.
    always_comb begin
        pend_d  = pend_q;
        done_d  = done_q;
        ipend_d = ipend_q;
        if (load)
            pend_d = pend_d & ~sel_oh_q;
        if (wb)
            done_d = done_d | sel_oh_q;
        if (wr_in) begin
            pend_d[chi] = 1'b1;
            done_d[chi] = 1'b0;
        end
        if (wr && wb_off == REG_PEND)
            ipend_d = ipend_d & ~NCH'(byte_merge(32'b0, wbs_dat_i, wbs_sel_i));
        if (wb)
            ipend_d = ipend_d | sel_oh_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            en_q     <= 1'b0;
            mask_q   <= '0;
            ipend_q  <= '0;
            pend_q   <= '0;
            done_q   <= '0;
            in_q     <= '0;
            out_q    <= '0;
            color_q  <= '0;
            sel_q    <= '0;
            sel_oh_q <= '0;
            last_q   <= '0;
            opnd_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q <= acc;
            if (acc)
                dat_q <= rd ? rdata : '0;
            if (wr_in)
                in_q[chi] <= DSIZE'(byte_merge(32'(in_q[chi]), wbs_dat_i, wbs_sel_i));
            if (wr && wb_off == REG_CTRL && wbs_sel_i[0])
                en_q <= wbs_dat_i[0];
            if (wr && wb_off == REG_MASK)
                mask_q <= NCH'(byte_merge(32'(mask_q), wbs_dat_i, wbs_sel_i));
            if (start) begin
                sel_q    <= arb_idx;
                sel_oh_q <= arb_gnt;
            end
            // Operand is snapshotted here; later IN writes only queue a new job.
            if (load)
                opnd_q <= in_q[sel_q];
            if (wb) begin
                out_q[sel_q]   <= result;
                color_q[sel_q] <= result[DSIZE-1 -: 8];
                last_q         <= sel_q;
            end
            pend_q  <= pend_d;
            done_q  <= done_d;
            ipend_q <= ipend_d;
            irq_q   <= |(ipend_q & mask_q);
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign ch_done_o = (state_q == ST_WB) ? sel_oh_q : '0;

endmodule

// File: tb/tb_gonso_mch_engine.sv
// Bench for gonso_mch_engine (NCH=4, DSIZE=32, LAT=4, INCR=1).
module tb_gonso_mch_engine;

    localparam int          NCH = 4;
    localparam logic [31:0] B   = 32'h3003_0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]     wbs_sel_i = '0;
    logic [31:0]    wbs_adr_i = '0, wbs_dat_i = '0;
    logic [31:0]    wbs_dat_o;
    logic           wbs_ack_o, irq, busy_o;
    logic [NCH-1:0] ch_done_o;

    always #5 clk = ~clk;

    gonso_mch_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .irq       (irq),
        .busy_o    (busy_o),
        .ch_done_o (ch_done_o)
    );

    int          n_chk = 0, n_err = 0;
    bit          sb_rd[$];
    logic [31:0] sb_exp[$];
    string       sb_nm[$];
    int          dq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations as the DUT acks and as results retire.
    bit          m_rd;
    logic [31:0] m_exp;
    string       m_nm;
    always @(negedge clk) begin
        if (wbs_ack_o) begin
            if (sb_rd.size() == 0)
                chk("unexpected_ack", 32'd1, 32'd0);
            else begin
                m_rd  = sb_rd.pop_front();
                m_exp = sb_exp.pop_front();
                m_nm  = sb_nm.pop_front();
                if (m_rd)
                    chk(m_nm, wbs_dat_o, m_exp);
            end
        end
        if (ch_done_o != '0) begin
            if (dq.size() == 0)
                chk("unexpected_done", 32'(ch_done_o), 32'd0);
            else
                chk("done_order", 32'(ch_done_o), 32'd1 << dq.pop_front());
        end
    end

    task automatic wb_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] exp, input string nm);
        bit got;
        sb_rd.push_back(!we);
        sb_exp.push_back(exp);
        sb_nm.push_back(nm);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) got = 1'b1;
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (!got) begin
            chk({nm, "_ack_timeout"}, 32'd0, 32'd1);
            void'(sb_rd.pop_back());
            void'(sb_exp.pop_back());
            void'(sb_nm.pop_back());
        end
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        wb_xfer(1'b1, adr, dat, sel, 32'd0, "wr");
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
        wb_xfer(1'b0, adr, 32'd0, 4'hF, exp, nm);
    endtask

    // Wait for a write-back pulse, then one more cycle so OUT is updated.
    task automatic wait_done(input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (ch_done_o != '0) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] cha(input int c, input logic [3:0] r);
        return B + 32'(c * 16) + {28'b0, r};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_done", 32'(ch_done_o), 32'd0);
        chk("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity, reset values, unmapped accesses
        rd(B + 32'h80C, 32'h0004_0420, "id");
        rd(cha(0, 4'h4), 32'd0, "out0_rst");
        wr(B + 32'h900, 32'hFFFF_FFFF);
        wr(32'h3004_0800, 32'h1);
        rd(B + 32'h800, 32'd0, "ctrl_untouched");
        rd(B + 32'h804, 32'd0, "mask_untouched");
        rd(32'h3004_080C, 32'd0, "other_base_rd");
        rd(cha(4, 4'h0), 32'd0, "ch4_unmapped");

        // Single job on ch0 with irq
        wr(B + 32'h800, 32'h1);
        wr(B + 32'h804, 32'h1);
        dq.push_back(0);
        wr(cha(0, 4'h0), 32'h0000_0010);
        wait_done("job0");
        rd(cha(0, 4'h4), 32'h0000_0011, "out0");
        rd(cha(0, 4'h8), 32'h0000_0000, "color0");
        rd(cha(0, 4'hC), 32'h0000_0004, "status0");
        chk("irq_set", {31'b0, irq}, 32'd1);
        rd(B + 32'h808, 32'h1, "ipend_set");
        wr(B + 32'h808, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("irq_clr", {31'b0, irq}, 32'd0);

        // Round-robin order after last_served = 0
        wr(B + 32'h800, 32'h0);
        wr(cha(3, 4'h0), 32'h3300_0005);
        wr(cha(1, 4'h0), 32'h0100_00FF);
        wr(cha(2, 4'h0), 32'h2200_0000);
        rd(cha(3, 4'hC), 32'h1, "status3_pend");
        dq.push_back(1); dq.push_back(2); dq.push_back(3);
        wr(B + 32'h800, 32'h1);
        wait_done("rr_a");
        wait_done("rr_b");
        wait_done("rr_c");
        rd(cha(1, 4'h4), 32'h0100_0100, "out1");
        rd(cha(1, 4'h8), 32'h0000_0001, "color1");
        rd(cha(2, 4'h4), 32'h2200_0001, "out2");
        rd(cha(2, 4'h8), 32'h0000_0022, "color2");
        rd(cha(3, 4'h4), 32'h3300_0006, "out3");
        chk("irq_masked", {31'b0, irq}, 32'd0);
        rd(B + 32'h808, 32'hE, "ipend_rr");
        wr(B + 32'h808, 32'hE);
        rd(B + 32'h808, 32'h0, "ipend_w1c");

        // Wrap, and an IN rewrite landing on the LOAD cycle
        dq.push_back(0); dq.push_back(0);
        wr(cha(0, 4'h0), 32'hFFFF_FFFF);
        wr(cha(0, 4'h0), 32'h7F00_0000);
        rd(cha(0, 4'hC), 32'h3, "status0_busy");
        wait_done("wrap");
        rd(cha(0, 4'h4), 32'h0, "out0_wrap");
        rd(cha(0, 4'h8), 32'h0, "color0_wrap");
        wait_done("rerun");
        rd(cha(0, 4'h4), 32'h7F00_0001, "out0_rerun");
        rd(cha(0, 4'h8), 32'h0000_007F, "color0_rerun");
        rd(cha(0, 4'hC), 32'h4, "status0_rerun");

        // Byte-lane write
        wr(B + 32'h800, 32'h0);
        wr(cha(2, 4'h0), 32'h0);
        wr(cha(2, 4'h0), 32'hAABB_CCDD, 4'b0010);
        rd(cha(2, 4'h0), 32'h0000_CC00, "in2_byte");
        rd(cha(2, 4'hC), 32'h1, "status2_pend");
        dq.push_back(2);
        wr(B + 32'h800, 32'h1);
        wait_done("byte");
        rd(cha(2, 4'h4), 32'h0000_CC01, "out2_byte");
        rd(cha(2, 4'hC), 32'h4, "status2_done");

        // Reset in the middle of a job
        wr(B + 32'h804, 32'hF);
        wr(cha(1, 4'h0), 32'h5);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_mid", {31'b0, busy_o}, 32'd1);
        chk("irq_pre_rst", {31'b0, irq}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", {31'b0, busy_o}, 32'd0);
        chk("rst_mid_irq", {31'b0, irq}, 32'd0);
        chk("rst_mid_done", 32'(ch_done_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(cha(1, 4'hC), 32'h0, "status1_rst");
        rd(cha(1, 4'h4), 32'h0, "out1_rst");
        rd(B + 32'h808, 32'h0, "ipend_rst");
        rd(B + 32'h800, 32'h0, "ctrl_rst");
        wr(B + 32'h800, 32'h1);
        dq.push_back(1);
        wr(cha(1, 4'h0), 32'h41);
        wait_done("post_rst");
        rd(cha(1, 4'h4), 32'h42, "out1_post");
        rd(cha(1, 4'hC), 32'h4, "status1_post");

        repeat (4) @(posedge clk);
        #1;
        chk("sb_left", 32'(sb_rd.size() + dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
